// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding encodings, stage records and match helpers for the hazard unit
package hazard_pkg;
  localparam int REG_W = 5;
  localparam int TNEW_W = 2;
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E = 2'd1;
  localparam logic [1:0] FWD_M = 2'd2;
  localparam logic [1:0] FWD_W = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  typedef struct packed {
    logic wen;
    logic [REG_W-1:0] addr;
  } dst_t;
  typedef struct packed {
    dst_t dst;
    logic [TNEW_W-1:0] tnew;
  } wr_rec_t;
  typedef struct packed {
    wr_rec_t wr;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic md_start;
    logic md_div;
  } e_rec_t;
  function automatic logic hit(dst_t d, logic [REG_W-1:0] src);
    return d.wen && d.addr != '0 && d.addr == src;
  endfunction
  function automatic logic [TNEW_W-1:0] tnew_dec(logic [TNEW_W-1:0] t);
    return t == '0 ? t : t - TNEW_W'(1);
  endfunction
endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// md_busy_counter: mult/div occupancy countdown loaded when an md instruction leaves E
module md_busy_counter #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);
  localparam int CW = $clog2((MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC) + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // load the op latency, otherwise count down and stop at zero
  always_comb begin
    busy = cnt_q != '0;
    cnt_d = load ? (div ? CW'(DIV_CYC) : CW'(MULT_CYC)) : busy ? cnt_q - CW'(1) : cnt_q;
  end
  // counter register; reset aborts any running operation
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage stall, E/M/W writer tracking and operand forwarding (HAZARD_FWD_EN enables forwarding)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic       d_wr_en,
  input  logic [4:0] d_wr_addr,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic [1:0] fwd_rt_m,
  output logic       md_busy
);
  e_rec_t e_q, e_d;
  wr_rec_t m_q, m_d;
  logic [REG_W-1:0] m_rt_q, m_rt_d;
  dst_t w_q, w_d;
  logic busy, rs_hz, rt_hz, md_hz;

  md_busy_counter #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
    .clk(clk),
    .reset(reset),
    .load(e_q.md_start),
    .div(e_q.md_div),
    .busy(busy)
  );

  // stall when a used operand is not ready in time or the md unit is occupied
  always_comb begin
`ifdef HAZARD_FWD_EN
    rs_hz = d_rs_tuse != TUSE_NONE && ((hit(e_q.wr.dst, d_rs) && e_q.wr.tnew > d_rs_tuse) || (hit(m_q.dst, d_rs) && m_q.tnew > d_rs_tuse));
    rt_hz = d_rt_tuse != TUSE_NONE && ((hit(e_q.wr.dst, d_rt) && e_q.wr.tnew > d_rt_tuse) || (hit(m_q.dst, d_rt) && m_q.tnew > d_rt_tuse));
`else
    rs_hz = d_rs_tuse != TUSE_NONE && (hit(e_q.wr.dst, d_rs) || hit(m_q.dst, d_rs));
    rt_hz = d_rt_tuse != TUSE_NONE && (hit(e_q.wr.dst, d_rt) || hit(m_q.dst, d_rt));
`endif
    md_hz = (d_md_use | d_md_start) && (busy || e_q.md_start);
    stall = !reset && (rs_hz || rt_hz || md_hz);
    md_busy = !reset && busy;
  end

`ifdef HAZARD_FWD_EN
  // youngest ready writer wins; W is covered by the GRF bypass for D
  always_comb begin
    fwd_rs_d = reset ? FWD_GRF : (hit(e_q.wr.dst, d_rs) && e_q.wr.tnew == '0) ? FWD_E : (hit(m_q.dst, d_rs) && m_q.tnew == '0) ? FWD_M : FWD_GRF;
    fwd_rt_d = reset ? FWD_GRF : (hit(e_q.wr.dst, d_rt) && e_q.wr.tnew == '0) ? FWD_E : (hit(m_q.dst, d_rt) && m_q.tnew == '0) ? FWD_M : FWD_GRF;
    fwd_rs_e = reset ? FWD_GRF : (hit(m_q.dst, e_q.rs) && m_q.tnew == '0) ? FWD_M : hit(w_q, e_q.rs) ? FWD_W : FWD_GRF;
    fwd_rt_e = reset ? FWD_GRF : (hit(m_q.dst, e_q.rt) && m_q.tnew == '0) ? FWD_M : hit(w_q, e_q.rt) ? FWD_W : FWD_GRF;
    fwd_rt_m = reset ? FWD_GRF : hit(w_q, m_rt_q) ? FWD_W : FWD_GRF;
  end
`else
  logic unused_fwd;
  // no forwarding paths: operands always come from the register file
  always_comb begin
    fwd_rs_d = FWD_GRF;
    fwd_rt_d = FWD_GRF;
    fwd_rs_e = FWD_GRF;
    fwd_rt_e = FWD_GRF;
    fwd_rt_m = FWD_GRF;
    unused_fwd = ^{m_q.tnew, m_rt_q, w_q, e_q.rs, e_q.rt};
  end
`endif

  // next stage records: bubble into E on stall, tnew counts down toward ready
  always_comb begin
    e_d = stall ? '0 : e_rec_t'{wr: '{dst: '{wen: d_wr_en, addr: d_wr_addr}, tnew: d_tnew}, rs: d_rs, rt: d_rt, md_start: d_md_start, md_div: d_md_start & d_md_div};
    m_d = '{dst: e_q.wr.dst, tnew: tnew_dec(e_q.wr.tnew)};
    m_rt_d = e_q.rt;
    w_d = m_q.dst;
  end

  // stage records advance every edge; reset clears all of them
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      m_rt_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      m_rt_q <= m_rt_d;
      w_q <= w_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random traffic checked against an in-flight instruction model
module tb_hazard_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N = 10;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk, reset;
  logic [4:0] d_rs, d_rt, d_wr_addr;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic d_wr_en, d_md_start, d_md_div, d_md_use;
  logic stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each accepted instruction remembers the cycle it sits in E; its stage is now-ent,
  // its remaining latency is tnew-(now-ent); the md unit is busy over a cycle window.
  typedef struct {
    logic wen;
    logic [4:0] addr;
    int tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    bit md;
    int ent;
  } ins_t;
  ins_t q[$];
  int cyc = 0;
  int md_lo = 0;
  int md_hi = 0;
  bit exp_stall, exp_busy;
  logic [1:0] exp_rs_d, exp_rt_d, exp_rs_e, exp_rt_e, exp_rt_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit find(input int ent, output ins_t r);
    bit f = 0;
    r = '{default: 0};
    foreach (q[i]) if (!f && q[i].ent == ent) begin
      r = q[i];
      f = 1;
    end
    return f;
  endfunction

  function automatic bit wr_hit(input int k, input logic [4:0] src, output int rem);
    ins_t r;
    bit f;
    f = find(cyc - k, r);
    rem = r.tnew - k;
    if (rem < 0) rem = 0;
    return f && r.wen && r.addr != 0 && r.addr == src;
  endfunction

  task automatic op_eval(input logic [4:0] s, input logic [1:0] u, output bit hz, output logic [1:0] sel);
    int re, rm;
    bit he, hm;
    he = wr_hit(0, s, re);
    hm = wr_hit(1, s, rm);
    if (FWD) begin
      hz = u != 2'd3 && ((he && re > int'(u)) || (hm && rm > int'(u)));
      sel = (he && re == 0) ? 2'd1 : (hm && rm == 0) ? 2'd2 : 2'd0;
    end else begin
      hz = u != 2'd3 && (he || hm);
      sel = 2'd0;
    end
  endtask

  task automatic model_eval();
    ins_t e, m;
    bit has_e, has_m, hz_rs, hz_rt, hm, hw;
    int rm, rx;
    exp_stall = 0; exp_busy = 0;
    exp_rs_d = 0; exp_rt_d = 0; exp_rs_e = 0; exp_rt_e = 0; exp_rt_m = 0;
    if (reset) return;
    exp_busy = cyc >= md_lo && cyc < md_hi;
    has_e = find(cyc, e);
    has_m = find(cyc - 1, m);
    op_eval(d_rs, d_rs_tuse, hz_rs, exp_rs_d);
    op_eval(d_rt, d_rt_tuse, hz_rt, exp_rt_d);
    exp_stall = hz_rs || hz_rt || ((d_md_use || d_md_start) && (exp_busy || (has_e && e.md)));
    if (FWD && has_e) begin
      hm = wr_hit(1, e.rs, rm); hw = wr_hit(2, e.rs, rx);
      exp_rs_e = (hm && rm == 0) ? 2'd2 : hw ? 2'd3 : 2'd0;
      hm = wr_hit(1, e.rt, rm); hw = wr_hit(2, e.rt, rx);
      exp_rt_e = (hm && rm == 0) ? 2'd2 : hw ? 2'd3 : 2'd0;
    end
    if (FWD && has_m) exp_rt_m = wr_hit(2, m.rt, rx) ? 2'd3 : 2'd0;
  endtask

  task automatic model_update();
    ins_t n;
    if (reset) begin
      q.delete();
      md_lo = 0;
      md_hi = 0;
    end else if (!exp_stall) begin
      n.wen = d_wr_en; n.addr = d_wr_addr; n.tnew = int'(d_tnew);
      n.rs = d_rs; n.rt = d_rt; n.md = d_md_start; n.ent = cyc + 1;
      q.push_back(n);
      if (d_md_start) begin
        md_lo = cyc + 2;
        md_hi = cyc + 2 + (d_md_div ? DIV_N : MULT_N);
      end
    end
    cyc++;
    while (q.size() > 0 && q[0].ent < cyc - 2) void'(q.pop_front());
  endtask

  // compare the DUT against the model for the current cycle, then advance one clock
  task automatic tick();
    #1;
    model_eval();
    check("stall", stall, exp_stall);
    check("md_busy", md_busy, exp_busy);
    if (!exp_stall) begin
      check("fwd_rs_d", fwd_rs_d, exp_rs_d);
      check("fwd_rt_d", fwd_rt_d, exp_rt_d);
    end
    check("fwd_rs_e", fwd_rs_e, exp_rs_e);
    check("fwd_rt_e", fwd_rt_e, exp_rt_e);
    check("fwd_rt_m", fwd_rt_m, exp_rt_m);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rsu, input logic [1:0] rtu,
                         input logic wen, input logic [4:0] wa, input logic [1:0] tn,
                         input logic mds, input logic mdd, input logic mdu);
    d_rs = rs; d_rt = rt; d_rs_tuse = rsu; d_rt_tuse = rtu; d_wr_en = wen; d_wr_addr = wa;
    d_tnew = tn; d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
  endtask

  task automatic nop();
    set_ins(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  // keep the D instruction in place until the DUT releases it; bounded
  task automatic hold_d(input string nm, input int exp_n);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (stall === 1'b0) done = 1;
      else begin
        n++;
        tick();
      end
    end
    check(nm, n, exp_n);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    int busy_n;
    reset = 1'b1;
    set_ins(1, 1, 0, 0, 1, 1, 2, 1, 1, 1);
    @(negedge clk);
    #1;
    check("reset_stall", stall, 0);
    check("reset_md_busy", md_busy, 0);
    check("reset_fwd_rs_d", fwd_rs_d, 0);
    tick();
    reset = 1'b0;
    drain();

    // 1: lw $1 then add $2,$1,$3
    set_ins(5, 6, 1, 3, 1, 1, 2, 0, 0, 0); tick();
    set_ins(1, 3, 1, 1, 1, 2, 1, 0, 0, 0);
    hold_d("s1_stall_cycles", FWD ? 1 : 2);
    tick();
    nop(); #1;
    check("s1_fwd_rs_e", fwd_rs_e, FWD ? 3 : 0);
    drain();

    // 2 and 6: add $1 then beq $1,$1
    set_ins(4, 5, 1, 1, 1, 1, 1, 0, 0, 0); tick();
    set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    hold_d("s2_stall_cycles", FWD ? 1 : 2);
    check("s2_fwd_rs_d", fwd_rs_d, FWD ? 2 : 0);
    check("s2_fwd_rt_d", fwd_rt_d, FWD ? 2 : 0);
    drain();

    // 3: lui $1 then jr $1
    set_ins(0, 0, 3, 3, 1, 1, 0, 0, 0, 0); tick();
    set_ins(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    hold_d("s3_stall_cycles", FWD ? 0 : 2);
    check("s3_fwd_rs_d", fwd_rs_d, FWD ? 1 : 0);
    drain();

    // 4: writer of $0 then reader of $0
    set_ins(0, 0, 3, 3, 1, 0, 1, 0, 0, 0); tick();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("s4_stall", stall, 0);
    check("s4_fwd_rs_d", fwd_rs_d, 0);
    check("s4_fwd_rt_d", fwd_rt_d, 0);
    tick();
    nop(); #1;
    check("s4_fwd_rs_e", fwd_rs_e, 0);
    check("s4_fwd_rt_e", fwd_rt_e, 0);
    drain();

    // 5: div then mflo, busy window length, reset mid-count
    set_ins(2, 3, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    set_ins(0, 0, 3, 3, 1, 4, 1, 0, 0, 1);
    hold_d("s5_mflo_stall", 1 + DIV_N);
    drain();
    set_ins(2, 3, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    nop();
    busy_n = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (md_busy === 1'b1) busy_n++;
      tick();
    end
    check("s5_busy_cycles", busy_n, DIV_N);
    set_ins(2, 3, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    nop(); tick();
    repeat (6) tick();
    #1;
    check("s5_busy_at_4", md_busy, 1);
    reset = 1'b1;
    set_ins(0, 0, 3, 3, 0, 0, 0, 0, 0, 1); #1;
    check("s5_in_reset_busy", md_busy, 0);
    check("s5_in_reset_stall", stall, 0);
    tick();
    reset = 1'b0; #1;
    check("s5_after_reset_busy", md_busy, 0);
    check("s5_after_reset_stall", stall, 0);
    drain();

    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      tick();
    end
    reset = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
